// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and the idle instruction value.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: req/ack instruction-memory read into a held instruction register.
// Optional FETCH_PERF_EN adds accepted-word and stall-cycle counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(FETCH_NOP)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] instrAddr,
    input  logic              flush,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memReq,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memData,
    output logic [DATA_W-1:0] instruction,
    output logic              instrValid,
    input  logic              instrReady,
    output logic              fetchStall
`ifdef FETCH_PERF_EN
   ,output logic [31:0]       fetchCount,
    output logic [31:0]       stallCount
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        valid_d = valid_q;
        instr_d = instr_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                addr_d  = instrAddr;
                req_d   = 1'b1;
            end
            REQ: begin
                if (memAck) begin
                    // A stale word still arrives after a flush; swallow it and refetch.
                    if (drop_q || flush) begin
                        drop_d = 1'b0;
                        addr_d = instrAddr;
                    end else begin
                        instr_d = memData;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (instrReady || flush) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    addr_d  = instrAddr;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

    assign memAddr     = addr_q;
    assign memReq      = req_q;
    assign instruction = instr_q;
    assign instrValid  = valid_q;
    assign fetchStall  = ~(valid_q & instrReady);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // A flushed word leaves HOLD but was never consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (valid_q && instrReady && !flush) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (fetchStall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch; compile with FETCH_PERF_EN to cover the counters.
module tb_instr_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] instrAddr;
    logic        flush;
    logic [15:0] memAddr;
    logic        memReq;
    logic        memAck;
    logic [31:0] memData;
    logic [31:0] instruction;
    logic        instrValid;
    logic        instrReady;
    logic        fetchStall;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
    int unsigned stall_m;
`endif

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    instr_fetch dut (
        .clock      (clock),
        .reset      (reset),
        .instrAddr  (instrAddr),
        .flush      (flush),
        .memAddr    (memAddr),
        .memReq     (memReq),
        .memAck     (memAck),
        .memData    (memData),
        .instruction(instruction),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .fetchStall (fetchStall)
`ifdef FETCH_PERF_EN
       ,.fetchCount (fetchCount),
        .stallCount (stallCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Consumer side: pop on each accepted handshake seen just before the edge.
    always @(negedge clock) begin
        #3;
        if (reset && instrValid && instrReady && !flush) begin
            if (exp_q.size() == 0) begin
                chk("sb_pending", exp_q.size(), 1);
            end else begin
                chk("sb_word", instruction, exp_q.pop_front());
            end
        end
`ifdef FETCH_PERF_EN
        if (!reset) stall_m = 0;
        else if (fetchStall) stall_m++;
`endif
    end

    task automatic serve(input logic [31:0] d, input int lat, input bit keep);
        int n;
        logic [15:0] a0;
        n = 0;
        while (!memReq && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", memReq, 1);
        a0 = memAddr;
        repeat (lat) begin
            chk("wait_req", memReq, 1);
            chk("wait_addr", memAddr, a0);
            chk("wait_valid", instrValid, 0);
            chk("wait_stall", fetchStall, 1);
            tick();
        end
        memAck  = 1'b1;
        memData = d;
        if (keep) exp_q.push_back(d);
        tick();
        memAck  = 1'b0;
        memData = 32'h0;
    endtask

    task automatic accept(input logic [15:0] next_addr);
        chk("acc_valid", instrValid, 1);
        instrAddr  = next_addr;
        instrReady = 1'b1;
        #1;
        chk("acc_stall", fetchStall, 0);
        tick();
        instrReady = 1'b0;
        chk("acc_req", memReq, 1);
        chk("acc_addr", memAddr, next_addr);
        chk("acc_valid0", instrValid, 0);
        chk("acc_nop", instruction, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        instrAddr = 16'h0040;
        flush = 1'b0;
        memAck = 1'b0;
        memData = 32'h0;
        instrReady = 1'b0;
        tick();
        tick();
        chk("rst_req", memReq, 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_valid", instrValid, 0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_stall", fetchStall, 1);
`ifdef FETCH_PERF_EN
        chk("rst_fcnt", fetchCount, 0);
        chk("rst_scnt", stallCount, 0);
`endif
        reset = 1'b1;
        tick();

        // 1: first fetch, ack one cycle after the request
        chk("t1_req", memReq, 1);
        chk("t1_addr", memAddr, 16'h0040);
        serve(32'h1234_5678, 0, 1);
        chk("t1_valid", instrValid, 1);
        chk("t1_instr", instruction, 32'h1234_5678);

        // 2: consumer stalls in HOLD, stray ack ignored
        instrAddr = 16'h0044;
        for (int i = 0; i < 3; i++) begin
            chk("t2_instr", instruction, 32'h1234_5678);
            chk("t2_stall", fetchStall, 1);
            chk("t2_req", memReq, 0);
            memAck  = (i == 1);
            memData = 32'hDEAD_BEEF;
            tick();
            memAck  = 1'b0;
        end
        chk("t2_hold", instruction, 32'h1234_5678);
        accept(16'h0044);

        // 3: slow memory
        serve(32'hCAFE_0001, 4, 1);
        chk("t3_instr", instruction, 32'hCAFE_0001);
        accept(16'h0048);

        // 4: flush while the request is outstanding
        flush = 1'b1;
        instrAddr = 16'h0080;
        tick();
        flush = 1'b0;
        chk("t4_req", memReq, 1);
        serve(32'hAAAA_0000, 1, 0);
        chk("t4_drop_valid", instrValid, 0);
        chk("t4_re_req", memReq, 1);
        chk("t4_re_addr", memAddr, 16'h0080);
        serve(32'hBBBB_0000, 0, 1);
        chk("t4_instr", instruction, 32'hBBBB_0000);
        accept(16'h0084);

        // 5: flush a held word
        serve(32'hC0C0_C0C0, 0, 0);
        chk("t5_valid", instrValid, 1);
        flush = 1'b1;
        instrAddr = 16'h0090;
        tick();
        flush = 1'b0;
        chk("t5_valid0", instrValid, 0);
        chk("t5_nop", instruction, 32'h0);
        chk("t5_req", memReq, 1);
        chk("t5_addr", memAddr, 16'h0090);

        // 6: reset mid-request, late ack ignored
        tick();
        reset = 1'b0;
        #1;
        chk("t6_req", memReq, 0);
        chk("t6_addr", memAddr, 0);
        chk("t6_valid", instrValid, 0);
        chk("t6_instr", instruction, 32'h0);
`ifdef FETCH_PERF_EN
        chk("t6_fcnt", fetchCount, 0);
        chk("t6_scnt", stallCount, 0);
`endif
        tick();
        reset = 1'b1;
        memAck = 1'b1;
        memData = 32'hBAD0_0BAD;
        instrAddr = 16'h00A0;
        tick();
        memAck = 1'b0;
        chk("t6_late_valid", instrValid, 0);
        chk("t6_late_req", memReq, 1);
        chk("t6_late_addr", memAddr, 16'h00A0);
        for (int i = 0; i < 3; i++) begin
            serve(32'h1000_0000 + i, i % 2, 1);
            accept(16'h00A4 + 16'(4 * i));
        end
`ifdef FETCH_PERF_EN
        chk("perf_fcnt", fetchCount, 3);
        chk("perf_scnt", stallCount, stall_m);
`endif
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
